button_gesture: RTL and testbench

Per-button gesture classifier that consumes the debounced, synchronised level from `switch_button` and emits single-cycle event pulses for short press, double press, long press and auto-repeat while held. It sits directly downstream of the debounce stage and replaces the plain `single_pulser` wherever UI logic (menus, value entry on seven-segment displays) needs more than a raw press edge. Each bit of the button bus is handled by an independent channel.

---
 rtl/button_gesture_pkg.sv | 23 ++
 rtl/button_gesture_channel.sv | 151 +++++++++++++++
 rtl/button_gesture.sv | 52 +++++
 tb/tb_button_gesture.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/button_gesture_pkg.sv
// ----------------------------------------------------------------------------
// button_gesture_pkg
// Shared definitions for the button gesture classifier.
//   - gesture_state_e : per-channel FSM state encoding (3 bits)
//   - DEFAULT_*       : default timing constants in clock cycles (50 MHz clock)
// No ports; imported by button_gesture and button_gesture_channel.
// ----------------------------------------------------------------------------
package button_gesture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } gesture_state_e;

    localparam int unsigned DEFAULT_CNT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_LONG_COUNT   = 32'd50_000_000;
    localparam logic [31:0] DEFAULT_DOUBLE_GAP   = 32'd25_000_000;
    localparam logic [31:0] DEFAULT_REPEAT_COUNT = 32'd10_000_000;

endpackage

// File: rtl/button_gesture_channel.sv
// ----------------------------------------------------------------------------
// button_gesture_channel
// Gesture classifier for a single debounced button: FSM plus timing counter.
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : asynchronous active-low reset
//   d        in  : debounced button level, 1 = pressed
//   short_p  out : one-cycle pulse per short press
//   double_p out : one-cycle pulse per double press
//   long_p   out : one-cycle pulse when a long press is recognised
//   repeat_p out : one-cycle pulse every REPEAT_COUNT cycles while long-held
//   held     out : high while the channel is in the long-hold state
// All outputs are registered.
// ----------------------------------------------------------------------------
module button_gesture_channel
    import button_gesture_pkg::*;
#(
    parameter int unsigned            CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter logic [CNT_WIDTH-1:0]   LONG_COUNT   = DEFAULT_LONG_COUNT,
    parameter logic [CNT_WIDTH-1:0]   DOUBLE_GAP   = DEFAULT_DOUBLE_GAP,
    parameter logic [CNT_WIDTH-1:0]   REPEAT_COUNT = DEFAULT_REPEAT_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic short_p,
    output logic double_p,
    output logic long_p,
    output logic repeat_p,
    output logic held
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = LONG_COUNT - CNT_ONE;
    localparam logic [CNT_WIDTH-1:0] GAP_LAST    = DOUBLE_GAP - CNT_ONE;
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = REPEAT_COUNT - CNT_ONE;

    gesture_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   d_q;
    logic                   short_q, short_d;
    logic                   double_q, double_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    logic                   held_q, held_d;
    logic                   rise, fall;

    // Next-state logic. Every transition that starts a new timed interval
    // reloads the counter with zero, so it can never pass its threshold.
    always_comb begin
        rise     = d & ~d_q;
        fall     = ~d & d_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_PRESS1: begin
                // A release on the threshold cycle takes priority over long.
                if (fall) begin
                    state_d = ST_WAIT2;
                    cnt_d   = CNT_ZERO;
                end else if (d && (cnt_q == LONG_LAST)) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT2: begin
                // A second press on the timeout cycle takes priority over short.
                if (rise) begin
                    state_d = ST_PRESS2;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d  = ST_IDLE;
                    double_d = 1'b1;
                end
            end
            ST_LONG: begin
                // Releasing ends the hold silently, even on a repeat boundary.
                if (fall) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (d && (cnt_q == REPEAT_LAST)) begin
                    repeat_d = 1'b1;
                    cnt_d    = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        held_d = (state_d == ST_LONG);
    end

    // State, counter and output registers. d_q resets high so a button that
    // is already pressed when reset releases does not look like a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            d_q      <= 1'b1;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign short_p  = short_q;
    assign double_p = double_q;
    assign long_p   = long_q;
    assign repeat_p = repeat_q;
    assign held     = held_q;

endmodule

// File: rtl/button_gesture.sv
// ----------------------------------------------------------------------------
// button_gesture
// Multi-button gesture classifier. Each bit of the debounced button bus is
// handled by an independent button_gesture_channel.
// Ports (all buses BUTTON_WIDTH wide, bit i belongs to button i):
//   clk      in  : clock, rising edge
//   rst_n    in  : asynchronous active-low reset
//   d        in  : debounced button levels, 1 = pressed
//   short_p  out : short press pulses
//   double_p out : double press pulses
//   long_p   out : long press pulses
//   repeat_p out : auto-repeat pulses while long-held
//   held     out : long-hold levels
// ----------------------------------------------------------------------------
module button_gesture
    import button_gesture_pkg::*;
#(
    parameter int unsigned            BUTTON_WIDTH = 1,
    parameter int unsigned            CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter logic [CNT_WIDTH-1:0]   LONG_COUNT   = DEFAULT_LONG_COUNT,
    parameter logic [CNT_WIDTH-1:0]   DOUBLE_GAP   = DEFAULT_DOUBLE_GAP,
    parameter logic [CNT_WIDTH-1:0]   REPEAT_COUNT = DEFAULT_REPEAT_COUNT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUTTON_WIDTH-1:0] d,
    output logic [BUTTON_WIDTH-1:0] short_p,
    output logic [BUTTON_WIDTH-1:0] double_p,
    output logic [BUTTON_WIDTH-1:0] long_p,
    output logic [BUTTON_WIDTH-1:0] repeat_p,
    output logic [BUTTON_WIDTH-1:0] held
);

    for (genvar i = 0; i < BUTTON_WIDTH; i++) begin : g_channel
        button_gesture_channel #(
            .CNT_WIDTH    (CNT_WIDTH),
            .LONG_COUNT   (LONG_COUNT),
            .DOUBLE_GAP   (DOUBLE_GAP),
            .REPEAT_COUNT (REPEAT_COUNT)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .d        (d[i]),
            .short_p  (short_p[i]),
            .double_p (double_p[i]),
            .long_p   (long_p[i]),
            .repeat_p (repeat_p[i]),
            .held     (held[i])
        );
    end

endmodule

// File: tb/tb_button_gesture.sv
// ----------------------------------------------------------------------------
// tb_button_gesture
// Directed bench for button_gesture with two channels and short timing
// (LONG_COUNT=8, DOUBLE_GAP=6, REPEAT_COUNT=4). Inputs are driven and outputs
// sampled on the falling clock edge; each sample is compared against a
// hand-derived output vector {short_p, double_p, long_p, repeat_p, held}.
// ----------------------------------------------------------------------------
module tb_button_gesture;

    logic       clk;
    logic       rst_n;
    logic [1:0] d;
    logic [1:0] short_p;
    logic [1:0] double_p;
    logic [1:0] long_p;
    logic [1:0] repeat_p;
    logic [1:0] held;

    int checks   = 0;
    int failures = 0;

    // Expected-vector building blocks, layout {short, double, long, repeat, held}.
    localparam logic [9:0] NONE    = 10'b00_00_00_00_00;
    localparam logic [9:0] SHORT0  = 10'b01_00_00_00_00;
    localparam logic [9:0] DOUBLE0 = 10'b00_01_00_00_00;
    localparam logic [9:0] DOUBLE1 = 10'b00_10_00_00_00;
    localparam logic [9:0] LONG0   = 10'b00_00_01_00_00;
    localparam logic [9:0] REP0    = 10'b00_00_00_01_00;
    localparam logic [9:0] HELD0   = 10'b00_00_00_00_01;

    button_gesture #(
        .BUTTON_WIDTH (2),
        .CNT_WIDTH    (32),
        .LONG_COUNT   (32'd8),
        .DOUBLE_GAP   (32'd6),
        .REPEAT_COUNT (32'd4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .short_p  (short_p),
        .double_p (double_p),
        .long_p   (long_p),
        .repeat_p (repeat_p),
        .held     (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares the current outputs against one expected vector.
    task automatic checkOutput(input string tag, input logic [9:0] expected);
        logic [9:0] observed;
        observed = {short_p, double_p, long_p, repeat_p, held};
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drives one input value through one rising edge, leaving us at the
    // following falling edge where that edge's outputs are stable.
    task automatic applyStimulus(input logic [1:0] dv);
        d = dv;
        @(negedge clk);
    endtask

    task automatic stepCheck(input logic [1:0] dv, input logic [9:0] expected, input string tag);
        applyStimulus(dv);
        checkOutput(tag, expected);
    endtask

    task automatic runCycles(input logic [1:0] dv, input int n, input logic [9:0] expected,
                             input string tag);
        for (int i = 0; i < n; i++) begin
            stepCheck(dv, expected, tag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 2'b00;
        #1;
        checkOutput("reset_state", NONE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runCycles(2'b00, 2, NONE, "post_reset_idle");

        // Short press: 3 cycles high, release, short_p 6 cycles after release.
        $display("[TB] short press");
        runCycles(2'b01, 3, NONE, "short_hold");
        stepCheck(2'b00, NONE, "short_release");
        runCycles(2'b00, 5, NONE, "short_gap");
        stepCheck(2'b00, SHORT0, "short_pulse");
        runCycles(2'b00, 3, NONE, "short_after");

        // Double press: 3 high, 2 low, 3 high, release.
        $display("[TB] double press");
        runCycles(2'b01, 3, NONE, "dbl_first");
        runCycles(2'b00, 2, NONE, "dbl_gap");
        runCycles(2'b01, 3, NONE, "dbl_second");
        stepCheck(2'b00, DOUBLE0, "dbl_pulse");
        runCycles(2'b00, 8, NONE, "dbl_no_short");

        // Long press held for edges 0..20, repeats at 12, 16, 20.
        $display("[TB] long press with repeat");
        runCycles(2'b01, 8, NONE, "long_wait");
        stepCheck(2'b01, LONG0 | HELD0, "long_pulse");
        for (int r = 0; r < 3; r++) begin
            runCycles(2'b01, 3, HELD0, "long_held");
            stepCheck(2'b01, REP0 | HELD0, "repeat_pulse");
        end
        stepCheck(2'b00, NONE, "long_release");
        runCycles(2'b00, 8, NONE, "long_no_short");

        // Release on the long threshold cycle: no long, short follows.
        $display("[TB] release at long threshold");
        runCycles(2'b01, 8, NONE, "bnd_long_hold");
        stepCheck(2'b00, NONE, "bnd_long_release");
        runCycles(2'b00, 5, NONE, "bnd_long_gap");
        stepCheck(2'b00, SHORT0, "bnd_long_short");
        runCycles(2'b00, 3, NONE, "bnd_long_after");

        // Second press on the gap timeout cycle: double, never short.
        $display("[TB] press at gap timeout");
        runCycles(2'b01, 2, NONE, "bnd_gap_first");
        stepCheck(2'b00, NONE, "bnd_gap_release");
        runCycles(2'b00, 5, NONE, "bnd_gap_wait");
        runCycles(2'b01, 2, NONE, "bnd_gap_second");
        stepCheck(2'b00, DOUBLE0, "bnd_gap_double");
        runCycles(2'b00, 8, NONE, "bnd_gap_after");

        // Reset while in long-hold with the button still down.
        $display("[TB] reset during long hold");
        runCycles(2'b01, 8, NONE, "rst_long_wait");
        stepCheck(2'b01, LONG0 | HELD0, "rst_long_pulse");
        runCycles(2'b01, 2, HELD0, "rst_long_held");
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_clear", NONE);
        @(negedge clk);
        checkOutput("rst_held_low", NONE);
        rst_n = 1'b1;
        runCycles(2'b01, 12, NONE, "rst_d_still_high");
        runCycles(2'b00, 2, NONE, "rst_d_release");
        runCycles(2'b01, 2, NONE, "rst_new_press");
        stepCheck(2'b00, NONE, "rst_new_release");
        runCycles(2'b00, 5, NONE, "rst_new_gap");
        stepCheck(2'b00, SHORT0, "rst_new_short");
        runCycles(2'b00, 2, NONE, "rst_new_after");

        // Long press on bit 0 concurrent with a double press on bit 1.
        $display("[TB] two independent channels");
        runCycles(2'b11, 3, NONE, "dual_a");
        runCycles(2'b01, 2, NONE, "dual_b");
        runCycles(2'b11, 3, NONE, "dual_c");
        stepCheck(2'b01, LONG0 | HELD0 | DOUBLE1, "dual_events");
        stepCheck(2'b01, HELD0, "dual_held");
        stepCheck(2'b00, NONE, "dual_release");
        runCycles(2'b00, 8, NONE, "dual_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
